// File: rtl/psr2_and_sched.sv
// Sequencer and round-robin arbiter sharing one psr2_and RSFQ gate among NREQ requesters.
// Optional gate_out-outside-window checker: define PSR2_SCHED_XCHECK_EN.
module psr2_and_sched #(
  parameter int NREQ      = 2,
  parameter int IDW       = 1,
  parameter int SETUP_CYC = 2,
  parameter int LAT_CYC   = 3,
  parameter int WIN_CYC   = 2,
  parameter int HOLD_CYC  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ-1:0] req_a,
  input  logic [NREQ-1:0] req_b,
  output logic [NREQ-1:0] req_ready,
  output logic            rsp_valid,
  output logic [IDW-1:0]  rsp_id,
  output logic            rsp_data,
  input  logic            rsp_ready,
  output logic            gate_a,
  output logic            gate_b,
  output logic            gate_clk,
  input  logic            gate_out,
  output logic            busy,
  output logic            err
);

  // state | meaning
  // IDLE  | waiting for a request, grant offered combinationally
  // SETUP | data pulse issued, counting down to the gate clock
  // CLKP  | gate_clk pulse cycle
  // WAIT  | gate latency before the capture window
  // CAPT  | OR-ing gate_out into the result
  // RESP  | response presented until rsp_ready
  // HOLD  | recovery interval before the next operation
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CLKP, S_WAIT, S_CAPT, S_RESP, S_HOLD
  } state_t;

  localparam int CW = 8;
  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ-1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  id;
  logic            res;

  logic [NREQ-1:0] rot;
  logic [IDW:0]    sum;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_any;
  logic            accept;

  // Rotate so bit 0 is the requester at ptr; the lowest set bit wins.
  always_comb begin
    rot     = NREQ'({req_valid, req_valid} >> ptr);
    gnt_any = 1'b0;
    sum     = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (rot[i]) begin
        gnt_any = 1'b1;
        sum     = {1'b0, ptr} + (IDW+1)'(i);
      end
    end
    if (sum >= NREQ_W) sum = sum - NREQ_W;
    gnt_id    = sum[IDW-1:0];
    req_ready = (state == S_IDLE && gnt_any) ? (NREQ'(1) << gnt_id) : '0;
  end

  assign accept = |(req_valid & req_ready);
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ptr       <= '0;
      id        <= '0;
      res       <= 1'b0;
      gate_a    <= 1'b0;
      gate_b    <= 1'b0;
      gate_clk  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= 1'b0;
    end else begin
      gate_a   <= 1'b0;
      gate_b   <= 1'b0;
      gate_clk <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            id     <= gnt_id;
            ptr    <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
            gate_a <= |(req_a & req_ready);
            gate_b <= |(req_b & req_ready);
            res    <= 1'b0;
            cnt    <= CW'(SETUP_CYC-1);
            state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            gate_clk <= 1'b1;
            state    <= S_CLKP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_CLKP: begin
          if (LAT_CYC == 1) begin
            cnt   <= CW'(WIN_CYC-1);
            state <= S_CAPT;
          end else begin
            cnt   <= CW'(LAT_CYC-2);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            cnt   <= CW'(WIN_CYC-1);
            state <= S_CAPT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_CAPT: begin
          res <= res | gate_out;
          if (cnt == '0) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id;
            rsp_data  <= res | gate_out;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (HOLD_CYC == 0) begin
              state <= S_IDLE;
            end else begin
              cnt   <= CW'(HOLD_CYC-1);
              state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (cnt == '0) state <= S_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PSR2_SCHED_XCHECK_EN
  // Any gate_out pulse outside the capture window is a protocol error; sticky until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (gate_out && state != S_CAPT) begin
      err <= 1'b1;
      $display("%m: gate_out pulse outside capture window at time %0d", $stime);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_psr2_and_sched.sv
// Self-checking bench for psr2_and_sched: timeline reference model checked every cycle,
// a table of single operations, directed corner sequences and a randomized run.
module tb_psr2_and_sched;
  localparam int NREQ = 2, IDW = 1, S = 2, L = 3, W = 2, H = 2;
  localparam int CAP_OFF = 1 + S + L;
  localparam int RSP_OFF = CAP_OFF + W;
`ifdef PSR2_SCHED_XCHECK_EN
  localparam bit XCHK = 1'b1;
`else
  localparam bit XCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [NREQ-1:0] req_valid, req_a, req_b, req_ready;
  logic rsp_valid, rsp_data, rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic gate_a, gate_b, gate_clk, gate_out, busy, err;

  always #5 clk = ~clk;

  psr2_and_sched #(.NREQ(NREQ), .IDW(IDW), .SETUP_CYC(S), .LAT_CYC(L), .WIN_CYC(W), .HOLD_CYC(H)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .gate_a(gate_a), .gate_b(gate_b), .gate_clk(gate_clk),
    .gate_out(gate_out), .busy(busy), .err(err));

  int n_cmp = 0, n_bad = 0, cyc = 0;

  logic [NREQ-1:0] d_valid = '0, d_a = '0, d_b = '0;
  logic d_rsp_ready = 1'b0, d_gout = 1'b0, d_rst_n = 1'b0;

  // Reference model: one in-flight operation described by its accept cycle.
  bit m_active = 0, m_hs = 0, m_err = 0, m_a = 0, m_b = 0, m_res = 0;
  int m_t = 0, m_id = 0, m_done_at = 0, m_ptr = 0;

  // Snapshot of what the DUT showed in the last stepped cycle.
  bit o_acc, o_hs, o_rv, o_ga, o_gb, o_gclk, o_busy, o_err, o_data;
  int o_acc_id, o_id, o_cyc;

  typedef struct {
    logic [NREQ-1:0] v, a, b;
    int pulse, exp_id, exp_data, exp_ga, exp_gb;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    logic [NREQ-1:0] e_ready;
    int gi, cap_lo;
    bit e_rv, in_cap;
    @(negedge clk);
    rst_n = d_rst_n; req_valid = d_valid; req_a = d_a; req_b = d_b;
    rsp_ready = d_rsp_ready; gate_out = d_gout;
    #1;
    if (m_active && m_hs && cyc >= m_done_at) m_active = 0;
    cap_lo = m_t + CAP_OFF;
    gi = -1;
    if (!m_active)
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (gi < 0 && d_valid[j]) gi = j;
      end
    e_ready = (gi >= 0) ? (NREQ'(1) << gi) : '0;
    e_rv = m_active && !m_hs && cyc >= m_t + RSP_OFF;
    check("req_ready", req_ready, e_ready);
    check("busy", busy, m_active);
    check("gate_a", gate_a, m_active && cyc == m_t + 1 && m_a);
    check("gate_b", gate_b, m_active && cyc == m_t + 1 && m_b);
    check("gate_clk", gate_clk, m_active && cyc == m_t + 1 + S);
    check("rsp_valid", rsp_valid, e_rv);
    check("err", err, m_err);
    if (e_rv) begin
      check("rsp_id", rsp_id, m_id);
      check("rsp_data", rsp_data, m_res);
    end
    o_cyc = cyc; o_acc = rst_n && |(req_valid & req_ready); o_acc_id = -1;
    for (int k = 0; k < NREQ; k++) if (req_ready[k]) o_acc_id = k;
    o_rv = rsp_valid; o_hs = rst_n && rsp_valid && rsp_ready; o_id = rsp_id; o_data = rsp_data;
    o_ga = gate_a; o_gb = gate_b; o_gclk = gate_clk; o_busy = busy; o_err = err;
    if (!d_rst_n) begin
      m_active = 0; m_ptr = 0; m_err = 0;
    end else begin
      in_cap = m_active && cyc >= cap_lo && cyc < cap_lo + W;
      if (XCHK && d_gout && !in_cap) m_err = 1;
      if (in_cap && d_gout) m_res = 1;
      if (e_rv && d_rsp_ready) begin m_hs = 1; m_done_at = cyc + 1 + H; end
      if (gi >= 0) begin
        m_active = 1; m_t = cyc; m_id = gi; m_a = d_a[gi]; m_b = d_b[gi];
        m_res = 0; m_hs = 0; m_ptr = (gi + 1) % NREQ;
      end
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    d_rst_n = 0; d_valid = '0; d_gout = 0; d_rsp_ready = 0;
    repeat (n) step();
    d_rst_n = 1;
  endtask

  task automatic wait_accept(output int t, output int id);
    int budget = 0;
    t = -1; id = -1;
    while (t < 0 && budget < 40) begin
      step();
      if (o_acc) begin t = o_cyc; id = o_acc_id; end
      budget++;
    end
    check("accept_seen", t >= 0, 1);
  endtask

  // One operation: accept, optional gate_out pulse at pulse_off, rsp_ready low for stall cycles.
  task automatic run_op(input logic [NREQ-1:0] v, a, b, keep, input int pulse_off, input int stall,
                        output int id, output int data, output int rise_off, output int hs_off,
                        output int ga_n, output int gb_n, output int clk_off, output int pulses_in_rsp,
                        output int rv_n);
    int t, budget, rise;
    bit done;
    d_a = a; d_b = b; d_gout = 0; d_rsp_ready = 1; d_valid = v;
    data = -1; rise_off = -1; hs_off = -1; ga_n = 0; gb_n = 0; clk_off = -1;
    pulses_in_rsp = 0; rv_n = 0; rise = -1; done = 0; budget = 0;
    wait_accept(t, id);
    d_valid = keep;
    while (!done && budget < 60 && t >= 0) begin
      d_gout = (cyc - t == pulse_off);
      d_rsp_ready = (stall == 0) || (rise >= 0 && cyc - rise >= stall);
      step();
      if (o_ga) ga_n++;
      if (o_gb) gb_n++;
      if (o_gclk) clk_off = o_cyc - t;
      if (o_rv) begin
        rv_n++;
        if (o_ga || o_gb || o_gclk) pulses_in_rsp++;
      end
      if (o_rv && rise < 0) begin rise = o_cyc; rise_off = o_cyc - t; end
      if (o_hs) begin done = 1; hs_off = o_cyc - t; data = o_data; end
      budget++;
    end
    d_gout = 0;
    check("op_done", done, 1);
  endtask

  initial begin
    int id, data, rise_off, hs_off, ga_n, gb_n, clk_off, pir, rv_n, t, hs_cyc, rv_seen;
    int acc_t[$], acc_id[$];

    tbl[0] = '{v: 2'b01, a: 2'b01, b: 2'b01, pulse: 6,  exp_id: 0, exp_data: 1, exp_ga: 1, exp_gb: 1};
    tbl[1] = '{v: 2'b10, a: 2'b10, b: 2'b00, pulse: -1, exp_id: 1, exp_data: 0, exp_ga: 1, exp_gb: 0};
    tbl[2] = '{v: 2'b10, a: 2'b10, b: 2'b10, pulse: 7,  exp_id: 1, exp_data: 1, exp_ga: 1, exp_gb: 1};
    tbl[3] = '{v: 2'b01, a: 2'b00, b: 2'b00, pulse: -1, exp_id: 0, exp_data: 0, exp_ga: 0, exp_gb: 0};
    tbl[4] = '{v: 2'b01, a: 2'b01, b: 2'b01, pulse: 5,  exp_id: 0, exp_data: 0, exp_ga: 1, exp_gb: 1};
    tbl[5] = '{v: 2'b10, a: 2'b10, b: 2'b10, pulse: 8,  exp_id: 1, exp_data: 0, exp_ga: 1, exp_gb: 1};

    rst_n = 0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 0; gate_out = 0;
    repeat (2) @(posedge clk);

    // Reset state
    do_reset(2);
    step();
    check("rst_busy", o_busy, 0);
    check("rst_rsp_valid", o_rv, 0);
    check("rst_gate_clk", o_gclk, 0);
    check("rst_err", o_err, 0);

    // Table of single operations
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].v, tbl[i].a, tbl[i].b, '0, tbl[i].pulse, 0,
             id, data, rise_off, hs_off, ga_n, gb_n, clk_off, pir, rv_n);
      check($sformatf("tbl%0d_id", i), id, tbl[i].exp_id);
      check($sformatf("tbl%0d_data", i), data, tbl[i].exp_data);
      check($sformatf("tbl%0d_ga", i), ga_n, tbl[i].exp_ga);
      check($sformatf("tbl%0d_gb", i), gb_n, tbl[i].exp_gb);
      check($sformatf("tbl%0d_clk_off", i), clk_off, 3);
      check($sformatf("tbl%0d_rsp_off", i), rise_off, 8);
    end

    // Arbitration: both requesters held, rsp_ready tied high
    do_reset(1);
    d_valid = 2'b11; d_a = 2'b11; d_b = 2'b01; d_rsp_ready = 1;
    repeat (45) begin
      step();
      if (o_acc) begin acc_t.push_back(o_cyc); acc_id.push_back(o_acc_id); end
    end
    check("arb_count", acc_t.size() >= 4, 1);
    if (acc_t.size() >= 4)
      for (int k = 0; k < 4; k++) begin
        check($sformatf("arb%0d_id", k), acc_id[k], k % 2);
        check($sformatf("arb%0d_t", k), acc_t[k] - acc_t[0], 11 * k);
      end
    d_valid = '0;
    repeat (15) step();

    // Back-pressure with requester 1 waiting
    run_op(2'b01, 2'b01, 2'b01, 2'b10, 6, 5,
           id, data, rise_off, hs_off, ga_n, gb_n, clk_off, pir, rv_n);
    check("bp_rsp_off", rise_off, 8);
    check("bp_hs_off", hs_off, 13);
    check("bp_rv_cycles", rv_n, 6);
    check("bp_pulses", pir, 0);
    check("bp_data", data, 1);
    hs_cyc = o_cyc;
    d_rsp_ready = 1;
    wait_accept(t, id);
    check("bp_hold", t - hs_cyc, 1 + H);
    check("bp_next_id", id, 1);
    d_valid = '0;
    repeat (15) step();

    // Reset in WAIT
    do_reset(1);
    d_valid = 2'b10; d_a = 2'b10; d_b = 2'b10; d_rsp_ready = 1;
    wait_accept(t, id);
    d_valid = '0;
    while (cyc < t + 4) step();
    d_rst_n = 0;
    step();
    d_rst_n = 1;
    step();
    check("mid_busy", o_busy, 0);
    check("mid_rv", o_rv, 0);
    check("mid_gates", {o_ga, o_gb, o_gclk}, 0);
    rv_seen = 0;
    repeat (20) begin step(); if (o_rv) rv_seen++; end
    check("mid_no_rsp", rv_seen, 0);
    d_valid = 2'b11;
    wait_accept(t, id);
    check("mid_next_id", id, 0);
    d_valid = '0;
    repeat (15) step();

    // gate_out pulse while idle
    do_reset(1);
    step(); step();
    d_gout = 1; step();
    d_gout = 0; step();
    check("xchk_err", o_err, XCHK);
    run_op(2'b01, 2'b01, 2'b01, '0, 7, 0,
           id, data, rise_off, hs_off, ga_n, gb_n, clk_off, pir, rv_n);
    check("xchk_op_data", data, 1);
    check("xchk_err_sticky", o_err, XCHK);
    do_reset(1);
    step();
    check("xchk_err_clr", o_err, 0);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      d_rst_n = ($urandom_range(0, 199) != 0);
      d_valid = NREQ'($urandom);
      d_a = NREQ'($urandom);
      d_b = NREQ'($urandom);
      d_rsp_ready = ($urandom_range(0, 9) < 7);
      d_gout = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/psr2_and_sched.md
# psr2_and_sched

Cycle-level sequencer and round-robin arbiter that shares one psr2_and RSFQ AND-gate instance among NREQ requesters. It accepts an operand pair, issues single-cycle data pulses on the gate's a/b inputs, then issues the gate clock pulse after the setup interval. It samples the gate's out pulse in a fixed capture window and returns the result with the requester ID. It then enforces a hold interval before the next operation. It sits between the testbench/system request fabric and the gate model.

## Interface
- NREQ, 2: number of requesters (2..4).
- IDW, 1: width of rsp_id; must satisfy 2^IDW ≥ NREQ.
- SETUP_CYC, 2: cycles from the data-pulse cycle to the gate_clk cycle; ≥1.
- LAT_CYC, 3: cycles from the gate_clk cycle to the first capture cycle; ≥1.
- WIN_CYC, 2: capture window length in cycles; ≥1.
- HOLD_CYC, 2: idle cycles after the response handshake before returning to IDLE; ≥0.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NREQ  per-requester request.
- req_a, req_b  in  NREQ  per-requester operand bits.
- req_ready  out  NREQ  one-hot grant; combinational; only in IDLE.
- rsp_valid  out  1  response valid.
- rsp_id  out  IDW  index of the served requester.
- rsp_data  out  1  AND result.
- rsp_ready  in  1  response accept.
- gate_a, gate_b, gate_clk  out  1  registered single-cycle pulses to the gate.
- gate_out  in  1  gate output pulse.
- busy  out  1  high when state ≠ IDLE.
- err  out  1  sticky protocol error (see Configuration).

## Operation
- States: IDLE → SETUP → CLKP → WAIT → CAPT → RESP → HOLD → IDLE.
- IDLE, grant:
  - Search req_valid starting at ptr and wrap; assert req_ready only for the first valid requester found.
  - On valid&ready, latch a, b and id; set ptr ← (id+1) mod NREQ.
  - Drive gate_a ← a and gate_b ← b (registered); go to SETUP.
- Operand value 0 produces no pulse on that input. gate_clk is issued regardless of operand values.
- SETUP: count SETUP_CYC−1 cycles. At the last count, register gate_clk ← 1 and go to CLKP.
- CLKP: single cycle; gate_clk is high here. Go to WAIT.
- WAIT: count LAT_CYC−1 cycles, then enter CAPT.
- CAPT: WIN_CYC cycles; res ← res | gate_out each cycle. res is cleared on accept.
- RESP: rsp_valid=1, rsp_id=id, rsp_data=res, all held stable until rsp_ready. On handshake go to HOLD, or to IDLE if HOLD_CYC=0.
- HOLD: count HOLD_CYC cycles, then IDLE.
- gate_out sampled outside CAPT is ignored for the result.
- Reset (rst_n=0 at a rising edge, in any state):
  - state=IDLE, ptr=0, counters=0, res=0.
  - gate_a, gate_b, gate_clk, rsp_valid, rsp_data, rsp_id, busy and err are all 0.
  - An in-flight operation is dropped with no response.
- Requesters not granted keep req_valid asserted; their request is not consumed.

## Timing
- Accept at cycle T:
  - gate_a/gate_b high in cycle T+1 only.
  - gate_clk high in cycle T+1+SETUP_CYC only.
  - Capture cycles are T+1+SETUP_CYC+LAT_CYC through +WIN_CYC−1.
  - rsp_valid rises in cycle T+1+SETUP_CYC+LAT_CYC+WIN_CYC.
- Response handshake at cycle R: IDLE in cycle R+1+HOLD_CYC; the next accept is possible in that same cycle.
- Defaults: accept T=0 gives data pulse at 1, clk at 3, capture 6–7, rsp_valid at 8.
- req_ready is never asserted while busy=1.

## Configuration
- PSR2_SCHED_XCHECK_EN defined: err is set when gate_out=1 in any cycle outside CAPT, including IDLE.
  - err stays set until reset.
  - Each such event also prints `$display` with `%m` and `$stime`.
- PSR2_SCHED_XCHECK_EN undefined: err tied 0 and no check logic is built.

## Test plan
- Basic AND, defaults:
  - Stimulus: req0 a=1 b=1 accepted at cycle 0; model pulses gate_out in cycle 6.
  - Required: gate_a=gate_b=1 in cycle 1, gate_clk=1 in cycle 3, rsp_valid=1 at cycle 8 with rsp_id=0, rsp_data=1.
- Zero operand:
  - Stimulus: req1 a=1 b=0; gate_out stays low.
  - Required: gate_b never pulses, gate_clk still pulses, rsp_data=0, rsp_id=1.
- Arbitration:
  - Stimulus: both req_valid held high; rsp_ready tied 1.
  - Required: grants alternate 0,1,0,1; accepts at cycles 0, 11, 22, 33.
- Back-pressure:
  - Stimulus: rsp_ready low for 5 cycles after rsp_valid rises.
  - Required: rsp_valid/rsp_id/rsp_data stable; req_ready=0; no gate pulses.
  - Required after the handshake: HOLD lasts 2 cycles.
- Reset mid-operation:
  - Stimulus: rst_n low for 1 cycle during WAIT.
  - Required: next cycle all outputs 0 and busy=0; no response is issued; the following request is granted to requester 0.
- Error check, macro defined:
  - Stimulus: gate_out pulse in IDLE at cycle 2.
  - Required: err=1 from cycle 3 until reset; the next operation completes normally.
  - Same stimulus with macro undefined: err=0.
